// File: rtl/left_shift_of_n_by_var_sequential.sv
// Iterative logical left shifter: one bit position per clock, one operation in flight,
// valid/ready on both sides. Outputs depend only on registered state.
module left_shift_of_n_by_var_sequential #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  data_r, data_nxt;
    logic [SW-1:0] cnt_r, cnt_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_r <= '0;
            cnt_r  <= '0;
        end else begin
            state  <= state_nxt;
            data_r <= data_nxt;
            cnt_r  <= cnt_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        data_nxt  = data_r;
        cnt_nxt   = cnt_r;
        case (state)
            IDLE: begin
                if (up_valid) begin
                    data_nxt  = up_data;
                    cnt_nxt   = up_shamt;
                    state_nxt = (up_shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                // cnt_r is at least 1 here, so the decrement cannot wrap
                data_nxt = {data_r[N-2:0], 1'b0};
                cnt_nxt  = cnt_r - SW'(1);
                if (cnt_r == SW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (down_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign up_ready   = (state == IDLE);
    assign down_valid = (state == DONE);
    assign down_data  = data_r;
    assign busy       = (state != IDLE);

endmodule
